// File: rtl/frequency_synthesizer_if.sv
// Request/response bundle for frequency_synthesizer.
//   requested_frequency : desired output frequency in N Hz units (master -> slave)
//   load                : request strobe (master -> slave)
//   busy                : conversion in progress (slave -> master)
//   valid               : phase_increment reflects the last accepted request
//   out_of_range        : last accepted request was above D/2 and clamped
//   phase_increment     : increment currently driving the accumulator
interface frequency_synthesizer_if #(
    parameter int W = 32
);
    logic [31:0]  requested_frequency;
    logic         load;
    logic         busy;
    logic         valid;
    logic         out_of_range;
    logic [W-1:0] phase_increment;

    modport master (
        output requested_frequency,
        output load,
        input  busy,
        input  valid,
        input  out_of_range,
        input  phase_increment
    );

    modport slave (
        input  requested_frequency,
        input  load,
        output busy,
        output valid,
        output out_of_range,
        output phase_increment
    );
endinterface

// File: rtl/frequency_synthesizer.sv
// Numerically controlled oscillator. A request in N Hz units is converted by a
// restoring long divider into a phase increment floor(R * 2^W / D), which then
// drives a free-running, phase-continuous accumulator.
//   clock             : reference clock
//   reset             : asynchronous, active-high reset
//   bus               : request/response interface (slave side)
//   synthesized_clock : MSB of the registered phase accumulator
//   strobe            : one-cycle pulse after each accumulator carry-out
module frequency_synthesizer #(
    parameter int FREQUENCY_OF_REFERENCE_CLOCK         = 10000000,
    parameter int N                                    = 100,
    parameter int FREQUENCY_OF_REFERENCE_CLOCK_IN_N_HZ = FREQUENCY_OF_REFERENCE_CLOCK / N,
    parameter int ACCUMULATOR_WIDTH                    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    frequency_synthesizer_if.slave  bus,
    output logic                    synthesized_clock,
    output logic                    strobe
);

    localparam int W     = ACCUMULATOR_WIDTH;
    localparam int D     = FREQUENCY_OF_REFERENCE_CLOCK_IN_N_HZ;
    // Remainder stays below D, so one extra bit holds the shifted value (< 2D).
    localparam int REM_W = $clog2(D) + 1;
    localparam int CNT_W = $clog2(W);

    localparam logic [REM_W-1:0] D_REM     = REM_W'(D);
    localparam logic [31:0]      HALF_D    = 32'(D / 2);
    localparam logic [W-1:0]     HALF_TURN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        APPLY
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [W-1:0]       quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clamp_q, clamp_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               oor_q, oor_d;
    logic [W-1:0]       inc_q, inc_d;
    logic [W-1:0]       phase_q, phase_d;
    logic               strobe_q, strobe_d;

    logic [W:0]         sum;
    logic [REM_W-1:0]   rem_shift;

    // Accumulator: runs every cycle on whatever increment is currently applied,
    // so a conversion in flight never disturbs the output phase.
    always_comb begin
        sum      = {1'b0, phase_q} + {1'b0, inc_q};
        phase_d  = sum[W-1:0];
        strobe_d = sum[W];
    end

    // Request FSM and restoring divider.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        clamp_d   = clamp_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        oor_d     = oor_q;
        inc_d     = inc_q;
        // rem_q < D <= 2^(REM_W-1), so the dropped MSB is always zero.
        rem_shift = {rem_q[REM_W-2:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    clamp_d = (bus.requested_frequency > HALF_D);
                    rem_d   = (bus.requested_frequency > HALF_D)
                              ? '0 : bus.requested_frequency[REM_W-1:0];
                    quot_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = DIVIDE;
                end
            end

            DIVIDE: begin
                if (rem_shift >= D_REM) begin
                    rem_d  = rem_shift - D_REM;
                    quot_d = {quot_q[W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    quot_d = {quot_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = APPLY;
                end
            end

            APPLY: begin
                inc_d   = clamp_q ? HALF_TURN : quot_q;
                oor_d   = clamp_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            clamp_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            oor_q    <= 1'b0;
            inc_q    <= '0;
            phase_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            clamp_q  <= clamp_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            oor_q    <= oor_d;
            inc_q    <= inc_d;
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.valid           = valid_q;
    assign bus.out_of_range    = oor_q;
    assign bus.phase_increment = inc_q;
    assign synthesized_clock   = phase_q[W-1];
    assign strobe              = strobe_q;

endmodule

// File: tb/tb_frequency_synthesizer.sv
module tb_frequency_synthesizer;

    localparam int W = 32;

    logic clock;
    logic reset;
    logic synthesized_clock;
    logic strobe;

    frequency_synthesizer_if #(.W(W)) bus ();

    frequency_synthesizer #(
        .FREQUENCY_OF_REFERENCE_CLOCK(10000000),
        .N(100),
        .ACCUMULATOR_WIDTH(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .synthesized_clock(synthesized_clock),
        .strobe(strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]  req;
        logic [W-1:0] inc;
        logic         oor;
    } vec_t;

    typedef struct {
        logic [W-1:0] inc;
        logic         oor;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Issue a request, check handshake timing, then pop and compare the result.
    task automatic do_request(input logic [31:0] req, input logic [W-1:0] inc, input logic oor);
        exp_t e;
        int n;
        @(negedge clock);
        bus.requested_frequency = req;
        bus.load = 1'b1;
        e.inc = inc;
        e.oor = oor;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.load = 1'b0;
        check("busy_after_load", 64'(bus.busy), 64'd1);
        check("valid_after_load", 64'(bus.valid), 64'd0);
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("busy_cycles", 64'(n + 1), 64'd34);
        e = sb.pop_front();
        check("phase_increment", 64'(bus.phase_increment), 64'(e.inc));
        check("out_of_range", 64'(bus.out_of_range), 64'(e.oor));
        check("valid", 64'(bus.valid), 64'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int cnt;
        int highs;
        int toggles;
        int last;
        int busy_fall;
        logic prev;

        vecs[0] = '{32'd25000,      32'd1073741824, 1'b0};
        vecs[1] = '{32'd10000,      32'd429496729,  1'b0};
        vecs[2] = '{32'd50000,      32'd2147483648, 1'b0};
        vecs[3] = '{32'd50001,      32'd2147483648, 1'b1};
        vecs[4] = '{32'd0,          32'd0,          1'b0};
        vecs[5] = '{32'd1,          32'd42949,      1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2147483648, 1'b1};
        vecs[7] = '{32'd12500,      32'd536870912,  1'b0};

        bus.requested_frequency = '0;
        bus.load = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_oor", 64'(bus.out_of_range), 64'd0);
        check("rst_inc", 64'(bus.phase_increment), 64'd0);
        check("rst_sclk", 64'(synthesized_clock), 64'd0);
        check("rst_strobe", 64'(strobe), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_request(vecs[i].req, vecs[i].inc, vecs[i].oor);
        end

        // 2.5 MHz: strobe every 4 cycles, square wave 2 high / 2 low.
        do_request(32'd25000, 32'd1073741824, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        cnt = 0; highs = 0; toggles = 0; prev = synthesized_clock;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (strobe) cnt++;
            if (synthesized_clock) highs++;
            if (synthesized_clock != prev) toggles++;
            prev = synthesized_clock;
        end
        check("strobes_2m5", 64'(cnt), 64'd10);
        check("highs_2m5", 64'(highs), 64'd20);
        check("toggles_2m5", 64'(toggles), 64'd20);

        // 1 MHz over 10000 cycles.
        do_request(32'd10000, 32'd429496729, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clock);
            #1;
            if (strobe) cnt++;
        end
        check_range("strobes_1m", cnt, 999, 1000);

        // R = 0 freezes the accumulator.
        do_request(32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        prev = synthesized_clock;
        cnt = 0; toggles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (strobe) cnt++;
            if (synthesized_clock != prev) toggles++;
        end
        check("zero_strobes", 64'(cnt), 64'd0);
        check("zero_toggles", 64'(toggles), 64'd0);

        // Loads during busy are dropped; the old increment keeps running.
        do_request(32'd25000, 32'd1073741824, 1'b0);
        @(negedge clock);
        bus.requested_frequency = 32'd25000;
        bus.load = 1'b1;
        sb.push_back('{32'd1073741824, 1'b0});
        @(posedge clock);
        #1;
        last = -1; busy_fall = -1; cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clock);
            bus.load = (e == 5 || e == 33);
            bus.requested_frequency = 32'd12500;
            @(posedge clock);
            #1;
            if (!bus.busy && busy_fall < 0) busy_fall = e;
            if (strobe) begin
                if (last >= 0 && e - last != 4) cnt++;
                last = e;
            end
        end
        bus.load = 1'b0;
        check("ignore_busy_fall", 64'(busy_fall), 64'd33);
        check("ignore_strobe_gaps", 64'(cnt), 64'd0);
        check("ignore_busy_idle", 64'(bus.busy), 64'd0);
        begin
            exp_t e;
            e = sb.pop_front();
            check("ignore_inc", 64'(bus.phase_increment), 64'(e.inc));
        end

        // Asynchronous reset at DIVIDE cycle 10 abandons the conversion.
        @(negedge clock);
        bus.requested_frequency = 32'd25000;
        bus.load = 1'b1;
        sb.push_back('{32'd1073741824, 1'b0});
        @(posedge clock);
        #1;
        bus.load = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_valid", 64'(bus.valid), 64'd0);
        check("arst_oor", 64'(bus.out_of_range), 64'd0);
        check("arst_inc", 64'(bus.phase_increment), 64'd0);
        check("arst_sclk", 64'(synthesized_clock), 64'd0);
        check("arst_strobe", 64'(strobe), 64'd0);
        void'(sb.pop_front());
        @(negedge clock);
        reset = 1'b0;
        do_request(32'd10000, 32'd429496729, 1'b0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
